// File: rtl/note_cmd_gen_pkg.sv
// Shared constants for the note recorder command generator.
//   OP_*     : recorder op encodings driven on the op bus
//   NOTE_W   : note code width
//   IDX_W    : record index width
//   ST_*     : debounce FSM state encodings
package note_cmd_gen_pkg;
  localparam int NOTE_W = 3;
  localparam int IDX_W  = 7;

  localparam logic [1:0] OP_REC = 2'b00;
  localparam logic [1:0] OP_QRY = 2'b01;
  localparam logic [1:0] OP_NOP = 2'b10;
  localparam logic [1:0] OP_CNT = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HELD   = 2'd2;
endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO for pending record notes.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push_i     : write din_i; accepted when not full, or when full and popping
//   pop_i      : read head; ignored when empty
//   din_i      : write data
//   dout_o     : head entry (valid when !empty_o)
//   full_o     : all DEPTH entries used
//   empty_o    : no entries
module note_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]               wr_q, rd_q;
  logic [DEPTH-1:0][W-1:0]   mem_q;
  logic                      do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a write when the head leaves at the same edge.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/note_cmd_gen.sv
// Upstream command generator for the note recorder.
// Debounces a raw key code into one record command per press, queues those
// in a small FIFO, and arbitrates them against host query/count requests,
// driving one registered recorder command per cycle.
//   clk, reset : clock, synchronous active-high reset
//   key, key_valid : raw keypad note and its valid
//   hold       : downstream stall, forces NOP and freezes queues
//   qry_req/qry_idx  : query request and record index
//   cnt_req/cnt_note : count request and note
//   op, note_in, query : registered recorder command bus
//   qry_busy, cnt_busy : request pending, new requests of that kind ignored
//   done       : one-cycle pulse, recorder result valid
//   ovf        : sticky, a press was dropped on a full FIFO
module note_cmd_gen
  import note_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] key,
  input  logic              key_valid,
  input  logic              hold,
  input  logic              qry_req,
  input  logic [IDX_W-1:0]  qry_idx,
  input  logic              cnt_req,
  input  logic [NOTE_W-1:0] cnt_note,
  output logic [1:0]        op,
  output logic [NOTE_W-1:0] note_in,
  output logic [IDX_W-1:0]  query,
  output logic              qry_busy,
  output logic              cnt_busy,
  output logic              done,
  output logic              ovf
);
  localparam int SCNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [SCNT_W-1:0] SCNT_ONE = SCNT_W'(1);

  // Debounce state
  logic [1:0]        st_q, st_d;
  logic [NOTE_W-1:0] cand_q, cand_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              push;

  // Request registers
  logic              qry_busy_q, cnt_busy_q;
  logic [IDX_W-1:0]  qidx_q;
  logic [NOTE_W-1:0] cnote_q;
  logic              qry_clr, cnt_clr;

  // Output registers
  logic [1:0]        op_q, op_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [IDX_W-1:0]  query_q, query_d;
  logic              done_q, ovf_q;

  // FIFO
  logic              pop, full, empty;
  logic [NOTE_W-1:0] head;

  note_fifo #(.DEPTH(FIFO_DEPTH), .W(NOTE_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (cand_d),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Debounce FSM. The pushed note is cand_d: in IDLE that is the fresh key,
  // in SETTLE it equals cand_q.
  always_comb begin
    st_d   = st_q;
    cand_d = cand_q;
    scnt_d = scnt_q;
    push   = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (key_valid) begin
          cand_d = key;
          scnt_d = SCNT_ONE;
          if (DEBOUNCE == 1) begin
            push = 1'b1;
            st_d = ST_HELD;
          end else begin
            st_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (!key_valid) begin
          st_d = ST_IDLE;
        end else if (key == cand_q) begin
          // >= keeps DEBOUNCE==1 from stalling after a HELD->SETTLE restart
          if (int'(scnt_q) + 1 >= DEBOUNCE) begin
            push = 1'b1;
            st_d = ST_HELD;
          end else begin
            scnt_d = scnt_q + SCNT_ONE;
          end
        end else begin
          cand_d = key;
          scnt_d = SCNT_ONE;
        end
      end
      ST_HELD: begin
        if (!key_valid) begin
          st_d = ST_IDLE;
        end else if (key != cand_q) begin
          cand_d = key;
          scnt_d = SCNT_ONE;
          st_d   = ST_SETTLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Issue arbiter: hold > record > query > count > nop.
  always_comb begin
    op_d    = OP_NOP;
    note_d  = note_q;
    query_d = query_q;
    pop     = 1'b0;
    qry_clr = 1'b0;
    cnt_clr = 1'b0;
    if (hold) begin
      op_d = OP_NOP;
    end else if (!empty) begin
      op_d   = OP_REC;
      note_d = head;
      pop    = 1'b1;
    end else if (qry_busy_q) begin
      op_d    = OP_QRY;
      query_d = qidx_q;
      qry_clr = 1'b1;
    end else if (cnt_busy_q) begin
      op_d    = OP_CNT;
      query_d = {{(IDX_W-NOTE_W){1'b0}}, cnote_q};
      cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= ST_IDLE;
      cand_q     <= '0;
      scnt_q     <= '0;
      qry_busy_q <= 1'b0;
      cnt_busy_q <= 1'b0;
      qidx_q     <= '0;
      cnote_q    <= '0;
      op_q       <= OP_NOP;
      note_q     <= '0;
      query_q    <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      st_q    <= st_d;
      cand_q  <= cand_d;
      scnt_q  <= scnt_d;
      op_q    <= op_d;
      note_q  <= note_d;
      query_q <= query_d;
      // op_q only carries QRY/CNT for one cycle, so this is a single pulse
      done_q  <= (op_q == OP_QRY) || (op_q == OP_CNT);
      if (push && full && !pop) ovf_q <= 1'b1;

      // A request can only be issued while busy, and busy blocks capture,
      // so clear and capture never collide.
      if (qry_clr)                    qry_busy_q <= 1'b0;
      else if (qry_req && !qry_busy_q) begin
        qry_busy_q <= 1'b1;
        qidx_q     <= qry_idx;
      end
      if (cnt_clr)                    cnt_busy_q <= 1'b0;
      else if (cnt_req && !cnt_busy_q) begin
        cnt_busy_q <= 1'b1;
        cnote_q    <= cnt_note;
      end
    end
  end

  assign op       = op_q;
  assign note_in  = note_q;
  assign query    = query_q;
  assign qry_busy = qry_busy_q;
  assign cnt_busy = cnt_busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
endmodule

// File: tb/tb_note_cmd_gen.sv
module tb_note_cmd_gen;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] key = '0;
  logic       key_valid = 1'b0;
  logic       hold = 1'b0;
  logic       qry_req = 1'b0;
  logic [6:0] qry_idx = '0;
  logic       cnt_req = 1'b0;
  logic [2:0] cnt_note = '0;
  logic [1:0] op;
  logic [2:0] note_in;
  logic [6:0] query;
  logic       qry_busy, cnt_busy, done, ovf;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  note_cmd_gen #(.DEBOUNCE(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .key(key), .key_valid(key_valid), .hold(hold),
    .qry_req(qry_req), .qry_idx(qry_idx), .cnt_req(cnt_req), .cnt_note(cnt_note),
    .op(op), .note_in(note_in), .query(query), .qry_busy(qry_busy),
    .cnt_busy(cnt_busy), .done(done), .ovf(ovf)
  );

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // one debounced press of note n under current hold, then release
  task automatic press(input logic [2:0] n);
    key = n; key_valid = 1'b1;
    repeat (4) step();
    key_valid = 1'b0;
    step();
  endtask

  initial begin
    int nrec;
    logic [2:0] last_note;
    logic seen3;

    // 1: reset
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk("rst_op", op, 2'b10);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_qbusy", qry_busy, 0);
    chk("rst_cbusy", cnt_busy, 0);
    chk("rst_note", note_in, 0);
    chk("rst_query", query, 0);

    // 2: key 5 held for 20 samples -> exactly one record, after edge 5
    key = 3'd5; key_valid = 1'b1;
    nrec = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (op == 2'b00) nrec++;
      if (i == 4) chk("t2_not_early", op, 2'b10);
      if (i == 5) begin
        chk("t2_op", op, 2'b00);
        chk("t2_note", note_in, 5);
      end
    end
    chk("t2_count", nrec, 1);
    key_valid = 1'b0;
    repeat (2) step();

    // 3: bounce 3,3,2,2,2,2 -> single record of 2
    nrec = 0; seen3 = 1'b0; last_note = '0;
    key_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 2) key = 3'd3;
      else if (i < 6) key = 3'd2;
      else key_valid = 1'b0;
      step();
      if (op == 2'b00) begin
        nrec++;
        last_note = note_in;
        if (note_in == 3'd3) seen3 = 1'b1;
        chk("t3_edge", i, 6);
      end
    end
    chk("t3_count", nrec, 1);
    chk("t3_note", last_note, 2);
    chk("t3_no3", seen3, 0);

    // 4: five presses under hold -> overflow; drain 1..4 in order
    hold = 1'b1;
    for (int n = 1; n <= 5; n++) press(3'(n));
    chk("t4_ovf", ovf, 1);
    chk("t4_hold_op", op, 2'b10);
    chk("t4_hold_note", note_in, 2);
    hold = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      step();
      chk("t4_op", op, 2'b00);
      chk("t4_note", note_in, n);
    end
    step();
    chk("t4_empty_op", op, 2'b10);
    chk("t4_ovf_sticky", ovf, 1);

    // 5: one queued record, then query and count in the same cycle
    hold = 1'b1;
    press(3'd7);
    chk("t5_hold_op", op, 2'b10);
    hold = 1'b0;
    qry_req = 1'b1; qry_idx = 7'd127;
    cnt_req = 1'b1; cnt_note = 3'd6;
    step();
    qry_req = 1'b0; cnt_req = 1'b0;
    chk("t5_rec_op", op, 2'b00);
    chk("t5_rec_note", note_in, 7);
    chk("t5_qbusy", qry_busy, 1);
    chk("t5_cbusy", cnt_busy, 1);
    step();
    chk("t5_qry_op", op, 2'b01);
    chk("t5_qry_idx", query, 127);
    chk("t5_done0", done, 0);
    step();
    chk("t5_cnt_op", op, 2'b11);
    chk("t5_cnt_q", query, 6);
    chk("t5_done_q", done, 1);
    chk("t5_qbusy_clr", qry_busy, 0);
    step();
    chk("t5_nop", op, 2'b10);
    chk("t5_done_c", done, 1);
    chk("t5_cbusy_clr", cnt_busy, 0);
    step();
    chk("t5_done_end", done, 0);

    // 6: reset with three matching samples taken -> nothing issued
    key = 3'd4; key_valid = 1'b1;
    repeat (3) step();
    reset = 1'b1; key_valid = 1'b0;
    step();
    reset = 1'b0;
    chk("t6_ovf_clr", ovf, 0);
    nrec = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (op != 2'b10) nrec++;
    end
    chk("t6_no_issue", nrec, 0);
    chk("t6_note", note_in, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
